dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder: the memory side of the data-port load/store request channel issued by the CPU MEM stage. It accepts one word request at a time over a valid/ready handshake, holds it for a programmable access latency, commits stores with byte strobes, and returns read data or an error over a valid/ready response channel. It replaces the zero-latency combinational data memory when stall-capable memory timing is modelled.

## Interface
Parameters:
- DEPTH_WORDS, 256: number of 32-bit words stored; power of two, ≥ 4.
- LATENCY, 2: clock edges from request acceptance to response; 1 to 15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  store byte enables; bit i enables wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request rejected (misaligned or out of range).

## Operation
- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1, resp_valid=0. On req_valid&&req_ready edge, latch write, addr, wdata, wstrb; load counter with LATENCY-1; go to WAIT.
- WAIT: req_ready=0. Each edge: counter 0 → go to RESP and perform access, else decrement.
- Access (on the WAIT→RESP edge):
  - word index = addr[31:2]; error if addr[1:0]≠0 or index ≥ DEPTH_WORDS (error checking per Configuration).
  - Error: memory untouched, resp_err=1, resp_rdata=0.
  - Load: resp_rdata = stored word.
  - Store: each byte with wstrb bit set is overwritten; other bytes kept; resp_rdata=0. wstrb=0 is a legal no-op store.
- RESP: resp_valid=1; resp_rdata/resp_err stable until handshake. On resp_valid&&resp_ready edge go to IDLE and clear resp_rdata/resp_err to 0.
- Request inputs are ignored outside IDLE; only one transaction in flight.
- Reset: state IDLE, counter 0, all memory words 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. Reset in WAIT or RESP aborts the transaction; a pending store is never committed; reset wins over any same-edge handshake.

## Timing
- resp_valid rises exactly LATENCY edges after the accepting edge (LATENCY=1: high the cycle right after acceptance plus one edge, i.e., accept at edge k, resp_valid high after edge k+1).
- Store becomes visible to a later load on the same edge resp_valid rises.
- Response may be held indefinitely by resp_ready=0; no data change while held.
- req_ready is high the cycle after the response handshake edge; minimum request-to-request spacing is LATENCY+2 edges.
- resp_ready high before resp_valid has no effect.
- Outputs are registered or decoded from registered state only; no combinational path from req_* or resp_ready to any output.

## Configuration
- DMEM_RESP_ERR_CHECK_EN defined: misaligned and out-of-range requests produce resp_err=1 as described.
- Not defined: no checking; word index = addr[log2(DEPTH_WORDS)+1:2] (upper bits and addr[1:0] ignored, address wraps); resp_err tied to 0.

## Test plan
- Reset then idle: rst=1 one edge → req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; load addr 0x10 returns 0x00000000.
- Store/load, LATENCY=2: store 0xDEADBEEF to 0x20, wstrb=4'hF → resp_valid exactly 2 edges after acceptance, rdata 0; then load 0x20 → 0xDEADBEEF.
- Byte strobes: word 0x20 = 0xDEADBEEF, store 0x11223344 wstrb=4'b0101 → load returns 0xDE22BE44.
- Backpressure: hold resp_ready=0 for 5 cycles on a load of 0x20 → resp_valid and rdata stable; req_valid pulses ignored; req_ready=1 only after the handshake.
- Errors (macro defined, DEPTH_WORDS=256): store to 0x22 and store to 0x400 → resp_err=1, rdata 0, later load of 0x20 unchanged; macro undefined: load 0x420 returns word at 0x20, resp_err=0.
- Reset mid-transaction: accept store 0xCAFEF00D to 0x30, assert rst during WAIT → resp_valid never rises; load 0x30 after reset returns 0.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word request at a time, fixed access latency, byte-strobed stores.
// Optional DMEM_RESP_ERR_CHECK_EN enables misalignment / out-of-range error responses.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [IDX_W-1:0] idx;
    logic             acc_err;
    logic             mem_we;

    assign idx = addr_q[IDX_W+1:2];

`ifdef DMEM_RESP_ERR_CHECK_EN
    assign acc_err = (addr_q[1:0] != 2'b00) || (addr_q[31:IDX_W+2] != '0);
`else
    // Without checking the address simply wraps; the dropped bits are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_q[31:IDX_W+2], addr_q[1:0]};
    assign acc_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wstrb_d = req_wstrb;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    err_d   = acc_err;
                    rdata_d = (!write_q && !acc_err) ? mem_q[idx] : 32'h0;
                    mem_we  = write_q && !acc_err;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wstrb_q <= 4'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (wstrb_q[b]) mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against a word-array reference model.
module tb_dmem_responder;
    localparam int DEPTH = 256;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [DEPTH];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    // Reference: a plain word array; errors only exist when the checking build is selected.
    task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output logic [31:0] rd, output logic er);
        int unsigned idx;
`ifdef DMEM_RESP_ERR_CHECK_EN
        er = (a % 4 != 0) || ((a / 4) >= DEPTH);
`else
        er = 1'b0;
`endif
        idx = (a / 4) % DEPTH;
        rd  = 32'h0;
        if (!er) begin
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            end else begin
                rd = model_mem[idx];
            end
        end
    endtask

    // Drives one transaction; while the response is held, spurious requests are offered and must be ignored.
    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input int hold, output logic [31:0] rd, output logic er, output int lat,
                       output logic stable, output logic post_ok);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_err; stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = ~d; req_wstrb = 4'hF;
            @(posedge clk); #1;
            if (!resp_valid || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) stable = 1'b0;
        end
        req_valid = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        post_ok = (req_ready === 1'b1) && (resp_valid === 1'b0) && (resp_rdata === 32'h0) && (resp_err === 1'b0);
    endtask

    task automatic test_reset;
        logic [31:0] rd, erd; logic er, eer, st, po; int lat;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        total++; if (req_ready !== 1'b1)   begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        total++; if (resp_valid !== 1'b0)  begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
        total++; if (resp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", resp_rdata); end
        total++; if (resp_err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b exp=0", resp_err); end
        model_access(1'b0, 32'h10, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'h0 || rd !== erd) begin bad++; $display("FAIL reset_load10 got=%h exp=00000000", rd); end
    endtask

    task automatic test_store_load;
        logic [31:0] rd, erd; logic er, eer, st, po; int lat;
        model_access(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, erd, eer);
        txn(1'b1, 32'h20, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, st, po);
        total++; if (lat !== LAT)  begin bad++; $display("FAIL store_latency got=%0d exp=%0d", lat, LAT); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata got=%h exp=0", rd); end
        total++; if (er !== 1'b0)  begin bad++; $display("FAIL store_err got=%b exp=0", er); end
        total++; if (!po) begin bad++; $display("FAIL store_post_handshake got=%b exp=1", po); end
        model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load20 got=%h exp=deadbeef", rd); end
        total++; if (lat !== LAT) begin bad++; $display("FAIL load_latency got=%0d exp=%0d", lat, LAT); end
    endtask

    task automatic test_strobes;
        logic [31:0] rd, erd; logic er, eer, st, po; int lat;
        model_access(1'b1, 32'h20, 32'h11223344, 4'b0101, erd, eer);
        txn(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, rd, er, lat, st, po);
        model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDE22BE44 || rd !== erd) begin bad++; $display("FAIL strobe_merge got=%h exp=de22be44", rd); end
        model_access(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, erd, eer);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, st, po);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDE22BE44) begin bad++; $display("FAIL zero_strobe got=%h exp=de22be44", rd); end
    endtask

    task automatic test_backpressure;
        logic [31:0] rd, erd; logic er, eer, st, po; int lat;
        model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 5, rd, er, lat, st, po);
        total++; if (rd !== erd) begin bad++; $display("FAIL bp_rdata got=%h exp=%h", rd, erd); end
        total++; if (!st) begin bad++; $display("FAIL bp_stable got=%b exp=1", st); end
        total++; if (!po) begin bad++; $display("FAIL bp_ready_after got=%b exp=1", po); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== erd) begin bad++; $display("FAIL bp_ignored_reqs got=%h exp=%h", rd, erd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd, erd; logic er, eer, st, po; int lat;
`ifdef DMEM_RESP_ERR_CHECK_EN
        model_access(1'b1, 32'h22, 32'h55555555, 4'hF, erd, eer);
        txn(1'b1, 32'h22, 32'h55555555, 4'hF, 0, rd, er, lat, st, po);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_misaligned got=%b/%h exp=1/0", er, rd); end
        model_access(1'b1, 32'h400, 32'h66666666, 4'hF, erd, eer);
        txn(1'b1, 32'h400, 32'h66666666, 4'hF, 0, rd, er, lat, st, po);
        total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL err_range got=%b/%h exp=1/0", er, rd); end
        model_access(1'b0, 32'h20, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDE22BE44 || er !== 1'b0) begin bad++; $display("FAIL err_untouched got=%h exp=de22be44", rd); end
`else
        model_access(1'b0, 32'h420, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h420, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDE22BE44 || er !== 1'b0) begin bad++; $display("FAIL wrap_load got=%h/%b exp=de22be44/0", rd, er); end
        model_access(1'b0, 32'h23, 32'h0, 4'h0, erd, eer);
        txn(1'b0, 32'h23, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'hDE22BE44 || er !== 1'b0) begin bad++; $display("FAIL misalign_ignored got=%h/%b exp=de22be44/0", rd, er); end
`endif
    endtask

    task automatic test_random;
        logic [31:0] rd, erd, a, d; logic er, eer, st, po, w; logic [3:0] s; int lat;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            d = $urandom; s = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: a = {22'h0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
                1: a = 32'($urandom_range(0, 7)) * 4;
                2: a = 32'($urandom_range(0, 31));
                default: a = $urandom;
            endcase
            model_access(w, a, d, s, erd, eer);
            txn(w, a, d, s, $urandom_range(0, 3), rd, er, lat, st, po);
            total++;
            if (rd !== erd || er !== eer || lat !== LAT || !st || !po) begin
                bad++;
                $display("FAIL rand_%0d w=%b a=%h got=%h/%b lat=%0d st=%b po=%b exp=%h/%b lat=%0d",
                         n, w, a, rd, er, lat, st, po, erd, eer, LAT);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd; logic er, st, po, seen; int lat;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(posedge clk); #1; req_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (resp_valid !== 1'b0) seen = 1'b1;
            @(posedge clk); #1;
        end
        total++; if (seen) begin bad++; $display("FAIL abort_resp_valid got=1 exp=0"); end
        txn(1'b0, 32'h30, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL abort_no_commit got=%h exp=0", rd); end
        txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, er, lat, st, po);
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL reset_clears_mem got=%h exp=0", rd); end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        test_reset();
        test_store_load();
        test_strobes();
        test_backpressure();
        test_errors();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
